// File: rtl/triangle_assembler.sv
// triangle_assembler
//   Groups a vertex stream into triangles. Each completed triangle and its colour
//   go into a small FIFO that feeds the rasterizer. The source cannot be stalled,
//   so a triangle that finds the FIFO full is dropped and flagged.
//
//   Optional build macro: TRI_ASSEMBLER_CULL_EN. When it is defined, a triangle
//   with any two identical vertices is discarded before the FIFO. It is not
//   pushed, not counted, and cannot cause overflow.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   vertex, color      incoming vertex {x,y,z}; colour is sampled with vertex 0 only
//   new_triangle       marks the cycle carrying vertex 0
//   active             frame envelope
//   tri_data/tri_color FIFO head {v0,v1,v2} and its colour
//   tri_valid/ready    head handshake
//   frame_done         1-cycle pulse on the cycle after active falls
//   frame_tri_count    pushes in the frame (saturating); valid with frame_done
//   overflow           sticky: complete triangle dropped on a full FIFO
//   malformed          sticky: partial triangle discarded
module triangle_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter int VERT_W     = 48,
  parameter int COLOR_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VERT_W-1:0]     vertex,
  input  logic [COLOR_W-1:0]    color,
  input  logic                  new_triangle,
  input  logic                  active,
  output logic [3*VERT_W-1:0]   tri_data,
  output logic [COLOR_W-1:0]    tri_color,
  output logic                  tri_valid,
  input  logic                  tri_ready,
  output logic                  frame_done,
  output logic [7:0]            frame_tri_count,
  output logic                  overflow,
  output logic                  malformed
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = 3*VERT_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] V1   = 2'd1;
  localparam logic [1:0] V2   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [VERT_W-1:0]  v0_q, v0_d, v1_q, v1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               malformed_q, malformed_d;
  logic               overflow_q, overflow_d;
  logic               active_q, active_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TW-1:0]      mem_data_q [FIFO_DEPTH];
  logic [TW-1:0]      mem_data_d [FIFO_DEPTH];
  logic [COLOR_W-1:0] mem_color_q [FIFO_DEPTH];
  logic [COLOR_W-1:0] mem_color_d [FIFO_DEPTH];
  logic [TW-1:0]      last_data_q, last_data_d;
  logic [COLOR_W-1:0] last_color_q, last_color_d;

  logic          push, push_ok, full, empty, pop, do_write;
  logic [TW-1:0] push_data;
  logic [7:0]    cnt_base;

  // Capture FSM: slot counter plus the vertex/colour registers.
  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    color_d     = color_q;
    malformed_d = malformed_q;
    push        = 1'b0;
    if (active && new_triangle) begin
      // A new vertex 0 restarts assembly; anything half-built is lost.
      v0_d    = vertex;
      color_d = color;
      state_d = V1;
      if (state_q != IDLE) malformed_d = 1'b1;
    end else if (active) begin
      case (state_q)
        V1: begin
          v1_d    = vertex;
          state_d = V2;
        end
        V2: begin
          push    = 1'b1;
          state_d = IDLE;
        end
        default: ; // stray vertex in IDLE, including the lead cycle
      endcase
    end else begin
      if (state_q != IDLE) malformed_d = 1'b1;
      state_d = IDLE;
    end
  end

  // v2 is taken straight from the input, so the push happens on the edge that ends the v2 cycle.
  assign push_data = {v0_q, v1_q, vertex};

`ifdef TRI_ASSEMBLER_CULL_EN
  logic degenerate;
  assign degenerate = (v0_q == v1_q) || (v1_q == vertex) || (v0_q == vertex);
  assign push_ok    = push && !degenerate;
`else
  assign push_ok    = push;
`endif

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop      = !empty && tri_ready;
  assign do_write = push_ok && (!full || pop);

  always_comb begin
    mem_data_d   = mem_data_q;
    mem_color_d  = mem_color_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    last_data_d  = last_data_q;
    last_color_d = last_color_q;
    overflow_d   = overflow_q | (push_ok && full && !pop);
    if (do_write) begin
      mem_data_d[wptr_q[AW-1:0]]  = push_data;
      mem_color_d[wptr_q[AW-1:0]] = color_q;
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      // The outgoing head is kept so the outputs hold their value once the FIFO drains.
      last_data_d  = mem_data_q[rptr_q[AW-1:0]];
      last_color_d = mem_color_q[rptr_q[AW-1:0]];
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // The frame counter clears on the cycle after frame_done. A push on that same edge starts the new count.
  always_comb begin
    active_d     = active;
    frame_done_d = active_q && !active;
    cnt_base     = frame_done_q ? 8'd0 : cnt_q;
    cnt_d        = (do_write && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      v0_q         <= '0;
      v1_q         <= '0;
      color_q      <= '0;
      malformed_q  <= 1'b0;
      overflow_q   <= 1'b0;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      last_data_q  <= '0;
      last_color_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i]  <= '0;
        mem_color_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      color_q      <= color_d;
      malformed_q  <= malformed_d;
      overflow_q   <= overflow_d;
      active_q     <= active_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      last_data_q  <= last_data_d;
      last_color_q <= last_color_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i]  <= mem_data_d[i];
        mem_color_q[i] <= mem_color_d[i];
      end
    end
  end

  assign tri_valid       = !empty;
  assign tri_data        = empty ? last_data_q  : mem_data_q[rptr_q[AW-1:0]];
  assign tri_color       = empty ? last_color_q : mem_color_q[rptr_q[AW-1:0]];
  assign frame_done      = frame_done_q;
  assign frame_tri_count = cnt_q;
  assign overflow        = overflow_q;
  assign malformed       = malformed_q;

endmodule

// File: tb/tb_triangle_assembler.sv
module tb_triangle_assembler;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [47:0]   vertex = '0;
  logic [15:0]   color = '0;
  logic          new_triangle = 1'b0;
  logic          active = 1'b0;
  logic [143:0]  tri_data;
  logic [15:0]   tri_color;
  logic          tri_valid;
  logic          tri_ready = 1'b1;
  logic          frame_done;
  logic [7:0]    frame_tri_count;
  logic          overflow;
  logic          malformed;

  int checks = 0;
  int errors = 0;

  logic [143:0] got_data [$];
  logic [15:0]  got_col  [$];
  int           fd_cnt   [$];

  triangle_assembler #(.FIFO_DEPTH(4), .VERT_W(48), .COLOR_W(16)) dut (
    .clk(clk), .rst(rst), .vertex(vertex), .color(color),
    .new_triangle(new_triangle), .active(active),
    .tri_data(tri_data), .tri_color(tri_color), .tri_valid(tri_valid),
    .tri_ready(tri_ready), .frame_done(frame_done),
    .frame_tri_count(frame_tri_count), .overflow(overflow), .malformed(malformed)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge; handshakes and frame_done are observed at negedge.
  always @(negedge clk) begin
    if (!rst && tri_valid && tri_ready) begin
      got_data.push_back(tri_data);
      got_col.push_back(tri_color);
    end
    if (!rst && frame_done) fd_cnt.push_back(int'(frame_tri_count));
  end

  // Sprite box: triangle k = (-16,0,z),(16,0,z),(-16,32,z), z = 176+16k, colour 0x0400+k.
  function automatic logic [47:0] vtx(input int k, input int i);
    logic [15:0] x, y, z;
    x = (i == 1) ? 16'sd16 : -16'sd16;
    y = (i == 2) ? 16'sd32 : 16'sd0;
    z = 16'(176 + 16*k);
    return {x, y, z};
  endfunction

  function automatic logic [143:0] exp_tri(input int k);
    return {vtx(k,0), vtx(k,1), vtx(k,2)};
  endfunction

  function automatic logic [15:0] exp_col(input int k);
    return 16'h0400 + 16'(k);
  endfunction

  task automatic drive(input logic act, input logic nt, input logic [47:0] v, input logic [15:0] c);
    active = act; new_triangle = nt; vertex = v; color = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  // Colour on non-slot-0 cycles is junk to prove it is ignored.
  task automatic send_tri(input int k);
    drive(1'b1, 1'b1, vtx(k,0), exp_col(k));
    drive(1'b1, 1'b0, vtx(k,1), 16'hDEAD);
    drive(1'b1, 1'b0, vtx(k,2), 16'hBEEF);
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; tri_ready = rdy;
    idle(2);
    rst = 1'b0;
    got_data.delete(); got_col.delete(); fd_cnt.delete();
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tri_valid); end
    checks++; if (tri_data !== 144'd0) begin errors++; $display("FAIL reset_data got %h want 0", tri_data); end
    checks++; if (overflow !== 1'b0 || malformed !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", overflow, malformed); end
    checks++; if (frame_done !== 1'b0 || frame_tri_count !== 8'd0) begin errors++; $display("FAIL reset_frame got %b/%0d want 0/0", frame_done, frame_tri_count); end
  endtask

  task automatic test_frame_stream;
    do_reset(1'b1);
    drive(1'b1, 1'b0, 48'h123456789ABC, 16'h1111); // lead cycle, ignored
    for (int k = 0; k < 10; k++) send_tri(k);
    idle(5);
    checks++; if (got_data.size() != 10) begin errors++; $display("FAIL stream_count got %0d want 10", got_data.size()); end
    checks++; if (got_data.size() > 0 && (got_data[0] !== {16'hFFF0,16'd0,16'd176,16'd16,16'd0,16'd176,16'hFFF0,16'd32,16'd176} || got_col[0] !== 16'h0400))
      begin errors++; $display("FAIL stream_first got %h/%h want (-16,0,176)(16,0,176)(-16,32,176)/0400", got_data[0], got_col[0]); end
    for (int k = 0; k < 10 && k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== exp_tri(k) || got_col[k] !== exp_col(k))
        begin errors++; $display("FAIL stream_tri%0d got %h/%h want %h/%h", k, got_data[k], got_col[k], exp_tri(k), exp_col(k)); end
    end
    checks++; if (fd_cnt.size() != 1 || fd_cnt[0] != 10) begin errors++; $display("FAIL stream_frame_done got %0d pulses cnt %0d want 1 pulse cnt 10", fd_cnt.size(), (fd_cnt.size() > 0) ? fd_cnt[0] : -1); end
    checks++; if (overflow !== 1'b0 || malformed !== 1'b0) begin errors++; $display("FAIL stream_flags got %b%b want 00", overflow, malformed); end
  endtask

  task automatic test_overflow;
    logic [143:0] d0;
    do_reset(1'b0);
    drive(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) send_tri(k);
    idle(3);
    checks++; if (tri_valid !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_state got valid %b ovf %b want 1 1", tri_valid, overflow); end
    checks++; if (fd_cnt.size() != 1 || fd_cnt[0] != 4) begin errors++; $display("FAIL ovf_frame_cnt got %0d pulses cnt %0d want 1 pulse cnt 4", fd_cnt.size(), (fd_cnt.size() > 0) ? fd_cnt[0] : -1); end
    d0 = tri_data;
    idle(3);
    checks++; if (tri_data !== d0 || tri_data !== exp_tri(0) || tri_color !== exp_col(0))
      begin errors++; $display("FAIL ovf_hold got %h/%h want %h/%h", tri_data, tri_color, exp_tri(0), exp_col(0)); end
    tri_ready = 1'b1;
    idle(8);
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL ovf_drain_count got %0d want 4", got_data.size()); end
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== exp_tri(k) || got_col[k] !== exp_col(k))
        begin errors++; $display("FAIL ovf_drain%0d got %h want %h", k, got_data[k], exp_tri(k)); end
    end
    checks++; if (tri_valid !== 1'b0 || tri_data !== exp_tri(3)) begin errors++; $display("FAIL ovf_empty_hold got %b/%h want 0/%h", tri_valid, tri_data, exp_tri(3)); end
  endtask

  task automatic test_malformed_restart;
    do_reset(1'b1);
    drive(1'b1, 1'b1, vtx(0,0), exp_col(0));
    drive(1'b1, 1'b0, vtx(0,1), 16'h0);
    send_tri(5);
    idle(4);
    checks++; if (malformed !== 1'b1) begin errors++; $display("FAIL restart_malformed got %b want 1", malformed); end
    checks++; if (got_data.size() != 1 || got_data[0] !== exp_tri(5) || got_col[0] !== exp_col(5))
      begin errors++; $display("FAIL restart_tri got %0d items first %h want 1 item %h", got_data.size(), (got_data.size() > 0) ? got_data[0] : 144'd0, exp_tri(5)); end
    checks++; if (fd_cnt.size() != 1 || fd_cnt[0] != 1) begin errors++; $display("FAIL restart_cnt got %0d pulses cnt %0d want cnt 1", fd_cnt.size(), (fd_cnt.size() > 0) ? fd_cnt[0] : -1); end
  endtask

  task automatic test_abort;
    do_reset(1'b1);
    drive(1'b1, 1'b1, vtx(1,0), exp_col(1));
    drive(1'b1, 1'b0, vtx(1,1), 16'h0);
    drive(1'b0, 1'b0, '0, '0); // active falls here
    checks++; if (malformed !== 1'b1 || frame_done !== 1'b1 || frame_tri_count !== 8'd0)
      begin errors++; $display("FAIL abort got malformed %b frame_done %b cnt %0d want 1 1 0", malformed, frame_done, frame_tri_count); end
    idle(3);
    checks++; if (got_data.size() != 0 || tri_valid !== 1'b0 || fd_cnt.size() != 1)
      begin errors++; $display("FAIL abort_nopush got %0d items %0d pulses want 0 items 1 pulse", got_data.size(), fd_cnt.size()); end
  endtask

  task automatic test_full_push_pop;
    do_reset(1'b0);
    drive(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) send_tri(k);
    drive(1'b1, 1'b1, vtx(4,0), exp_col(4));
    drive(1'b1, 1'b0, vtx(4,1), 16'h0);
    tri_ready = 1'b1;
    drive(1'b1, 1'b0, vtx(4,2), 16'h0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got %b want 0", overflow); end
    idle(8);
    checks++; if (got_data.size() != 5) begin errors++; $display("FAIL fullpp_count got %0d want 5", got_data.size()); end
    for (int k = 0; k < 5 && k < got_data.size(); k++) begin
      checks++; if (got_data[k] !== exp_tri(k)) begin errors++; $display("FAIL fullpp_tri%0d got %h want %h", k, got_data[k], exp_tri(k)); end
    end
    checks++; if (fd_cnt.size() != 1 || fd_cnt[0] != 5) begin errors++; $display("FAIL fullpp_cnt got %0d want 5", (fd_cnt.size() > 0) ? fd_cnt[0] : -1); end
  endtask

  task automatic test_degenerate;
    int exp_n;
`ifdef TRI_ASSEMBLER_CULL_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    do_reset(1'b1);
    drive(1'b1, 1'b1, vtx(6,0), exp_col(6));
    drive(1'b1, 1'b0, vtx(6,1), 16'h0);
    drive(1'b1, 1'b0, vtx(6,1), 16'h0);
    idle(4);
    checks++; if (got_data.size() != exp_n) begin errors++; $display("FAIL degen_count got %0d want %0d", got_data.size(), exp_n); end
    checks++; if (exp_n == 1 && got_data.size() == 1 && got_data[0] !== {vtx(6,0), vtx(6,1), vtx(6,1)})
      begin errors++; $display("FAIL degen_data got %h want %h", got_data[0], {vtx(6,0), vtx(6,1), vtx(6,1)}); end
    checks++; if (fd_cnt.size() != 1 || fd_cnt[0] != exp_n || overflow !== 1'b0)
      begin errors++; $display("FAIL degen_frame got cnt %0d ovf %b want %0d 0", (fd_cnt.size() > 0) ? fd_cnt[0] : -1, overflow, exp_n); end
    // Mid-triangle reset after a malformed restart.
    drive(1'b1, 1'b1, vtx(7,0), exp_col(7));
    drive(1'b1, 1'b0, vtx(7,1), 16'h0);
    drive(1'b1, 1'b1, vtx(8,0), exp_col(8));
    drive(1'b1, 1'b0, vtx(8,1), 16'h0);
    checks++; if (malformed !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", malformed); end
    rst = 1'b1;
    drive(1'b1, 1'b0, vtx(8,2), 16'h0);
    checks++; if (tri_valid !== 1'b0 || tri_data !== 144'd0 || tri_color !== 16'd0 || malformed !== 1'b0 ||
                  overflow !== 1'b0 || frame_done !== 1'b0 || frame_tri_count !== 8'd0)
      begin errors++; $display("FAIL rstmid_outputs got v%b d%h c%h m%b o%b fd%b n%0d want all 0", tri_valid, tri_data, tri_color, malformed, overflow, frame_done, frame_tri_count); end
    rst = 1'b0;
    idle(3);
    checks++; if (tri_valid !== 1'b0 || fd_cnt.size() != 1) begin errors++; $display("FAIL rstmid_after got valid %b pulses %0d want 0 1", tri_valid, fd_cnt.size()); end
  endtask

  initial begin
    test_reset();
    test_frame_stream();
    test_overflow();
    test_malformed_restart();
    test_abort();
    test_full_push_pop();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
